// File: rtl/debnc_scan_ctrl.sv
// debnc_scan_ctrl: multi-channel switch debouncer.
// One shared tick generator paces every channel's debounce FSM; accepted
// edges are parked in a per-channel pending store and serialised through a
// round-robin arbiter onto a single valid/ready event port.
// Optional build macro: DEBNC_EARLY_EN selects the early (leading-edge)
// scheme, where a level change is reported immediately and the following
// N_TICKS ticks act as a lock-out. Without it the level is only accepted
// after N_TICKS consecutive stable ticks.
module debnc_scan_ctrl #(
  parameter int N_SW     = 4,
  parameter int TICK_DIV = 100000,
  parameter int N_TICKS  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_SW-1:0]         sw,
  output logic [N_SW-1:0]         db_level,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [$clog2(N_SW)-1:0] evt_ch,
  output logic                    evt_rise,
  output logic                    evt_ovf
);

  localparam int CH_W  = $clog2(N_SW);
  localparam int TCK_W = $clog2(TICK_DIV);
  localparam int CNT_W = $clog2(N_TICKS + 1);

  typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_e;

  logic [N_SW-1:0]  sync_a;
  logic [N_SW-1:0]  sync_b;
  logic [TCK_W-1:0] tick_cnt;
  logic             tick;

  db_state_e        state_q [N_SW];
  db_state_e        state_d [N_SW];
  logic [CNT_W-1:0] cnt_q   [N_SW];
  logic [CNT_W-1:0] cnt_d   [N_SW];

  logic [N_SW-1:0]  level_d;
  logic [N_SW-1:0]  edge_set;
  logic [N_SW-1:0]  edge_pol;

  logic [N_SW-1:0]  pend;
  logic [N_SW-1:0]  pol;
  logic [CH_W-1:0]  rr_ptr;

  logic             load;
  logic             found;
  logic [CH_W-1:0]  grant;
  logic [CH_W-1:0]  idx;
  logic [N_SW-1:0]  grant_oh;

  // Two-flop synchroniser per raw switch bit; the FSMs only ever see sync_b.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= sw;
      sync_b <= sync_a;
    end
  end

  // Shared tick prescaler: wraps at TICK_DIV-1, tick is high for that one count.
  assign tick = (tick_cnt == TCK_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TCK_W'(1);
    end
  end

  // Debounce FSM state and stability down-counter for every channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_SW; i++) begin
        state_q[i] <= ZERO;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Next-state logic: start a stability window on a level change, count ticks.
  always_comb begin
    for (int i = 0; i < N_SW; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
`ifdef DEBNC_EARLY_EN
      unique case (state_q[i])
        ZERO: begin
          if (sync_b[i]) begin
            state_d[i] = WAIT1;
            cnt_d[i]   = CNT_W'(N_TICKS);
          end
        end
        WAIT1: begin
          if (tick) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
            if (cnt_q[i] == CNT_W'(1)) state_d[i] = ONE;
          end
        end
        ONE: begin
          if (!sync_b[i]) begin
            state_d[i] = WAIT0;
            cnt_d[i]   = CNT_W'(N_TICKS);
          end
        end
        WAIT0: begin
          if (tick) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
            if (cnt_q[i] == CNT_W'(1)) state_d[i] = ZERO;
          end
        end
        default: state_d[i] = ZERO;
      endcase
`else
      unique case (state_q[i])
        ZERO: begin
          if (sync_b[i]) begin
            state_d[i] = WAIT1;
            cnt_d[i]   = CNT_W'(N_TICKS);
          end
        end
        WAIT1: begin
          if (!sync_b[i]) begin
            state_d[i] = ZERO;
          end else if (tick) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
            if (cnt_q[i] == CNT_W'(1)) state_d[i] = ONE;
          end
        end
        ONE: begin
          if (!sync_b[i]) begin
            state_d[i] = WAIT0;
            cnt_d[i]   = CNT_W'(N_TICKS);
          end
        end
        WAIT0: begin
          if (sync_b[i]) begin
            state_d[i] = ONE;
          end else if (tick) begin
            cnt_d[i] = cnt_q[i] - CNT_W'(1);
            if (cnt_q[i] == CNT_W'(1)) state_d[i] = ZERO;
          end
        end
        default: state_d[i] = ZERO;
      endcase
`endif
    end
  end

  // Output decode: debounced level of the next state and accepted-edge strobes.
  always_comb begin
    level_d  = '0;
    edge_set = '0;
    edge_pol = '0;
    for (int i = 0; i < N_SW; i++) begin
`ifdef DEBNC_EARLY_EN
      level_d[i] = (state_d[i] == WAIT1) || (state_d[i] == ONE);
      if (state_q[i] == ZERO && state_d[i] == WAIT1) begin
        edge_set[i] = 1'b1;
        edge_pol[i] = 1'b1;
      end
      if (state_q[i] == ONE && state_d[i] == WAIT0) begin
        edge_set[i] = 1'b1;
        edge_pol[i] = 1'b0;
      end
`else
      level_d[i] = (state_d[i] == ONE) || (state_d[i] == WAIT0);
      if (state_q[i] == WAIT1 && state_d[i] == ONE) begin
        edge_set[i] = 1'b1;
        edge_pol[i] = 1'b1;
      end
      if (state_q[i] == WAIT0 && state_d[i] == ZERO) begin
        edge_set[i] = 1'b1;
        edge_pol[i] = 1'b0;
      end
`endif
    end
  end

  // Registered debounced level, aligned with the FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_level <= '0;
    end else begin
      db_level <= level_d;
    end
  end

  // Round-robin search for the next pending channel, starting after rr_ptr.
  always_comb begin
    load     = !evt_valid || evt_ready;
    found    = 1'b0;
    grant    = '0;
    idx      = '0;
    grant_oh = '0;
    if (load) begin
      for (int k = 0; k < N_SW; k++) begin
        idx = CH_W'((int'(rr_ptr) + 1 + k) % N_SW);
        if (!found && pend[idx]) begin
          found = 1'b1;
          grant = idx;
        end
      end
    end
    if (found) grant_oh[grant] = 1'b1;
  end

  // Pending store: a new edge always wins over a same-cycle grant; an edge
  // landing on a still-pending, ungranted channel raises the sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend    <= '0;
      pol     <= '0;
      evt_ovf <= 1'b0;
    end else begin
      for (int i = 0; i < N_SW; i++) begin
        if (edge_set[i]) begin
          pend[i] <= 1'b1;
          pol[i]  <= edge_pol[i];
        end else if (grant_oh[i]) begin
          pend[i] <= 1'b0;
        end
      end
      if (|(edge_set & pend & ~grant_oh)) evt_ovf <= 1'b1;
    end
  end

  // Event output register: reloads when empty or on a handshake, else holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rise  <= 1'b0;
      rr_ptr    <= CH_W'(N_SW - 1);
    end else if (load) begin
      if (found) begin
        evt_valid <= 1'b1;
        evt_ch    <= grant;
        evt_rise  <= pol[grant];
        rr_ptr    <= grant;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_debnc_scan_ctrl.sv
// tb_debnc_scan_ctrl: self-checking bench for debnc_scan_ctrl with a
// behavioural model (per-channel settle countdown, pending table, rotating
// grant) stepped once per clock. Honours DEBNC_EARLY_EN like the design.
module tb_debnc_scan_ctrl;

  localparam int N_SW     = 4;
  localparam int TICK_DIV = 4;
  localparam int N_TICKS  = 3;
  localparam int CHW      = $clog2(N_SW);
  localparam int VW       = N_SW + CHW + 3;

  logic            clk;
  logic            rst;
  logic [N_SW-1:0] sw;
  logic [N_SW-1:0] db_level;
  logic            evt_valid;
  logic            evt_ready;
  logic [CHW-1:0]  evt_ch;
  logic            evt_rise;
  logic            evt_ovf;

  int total = 0;
  int bad   = 0;

  // model state
  logic [N_SW-1:0] m_s1, m_s2, m_lvl, m_pend, m_pol;
  int              m_left [N_SW];
  int              m_phase, m_rr;
  logic            m_valid, m_rise, m_ovf;
  logic [CHW-1:0]  m_ch;

  debnc_scan_ctrl #(.N_SW(N_SW), .TICK_DIV(TICK_DIV), .N_TICKS(N_TICKS)) dut (
    .clk(clk), .rst(rst), .sw(sw), .db_level(db_level),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_ch(evt_ch),
    .evt_rise(evt_rise), .evt_ovf(evt_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_pol = '0;
    for (int i = 0; i < N_SW; i++) m_left[i] = 0;
    m_phase = 0; m_rr = N_SW - 1;
    m_valid = 1'b0; m_rise = 1'b0; m_ovf = 1'b0; m_ch = '0;
  endtask

  // Advance the model by one clock using the inputs seen at that edge.
  task automatic model_update();
    logic tk;
    logic found;
    int   g;
    int   idx;
    tk = (m_phase == TICK_DIV - 1);
    if (!m_valid || evt_ready) begin
      found = 1'b0;
      g = 0;
      for (int k = 0; k < N_SW; k++) begin
        idx = (m_rr + 1 + k) % N_SW;
        if (!found && m_pend[idx]) begin
          found = 1'b1;
          g = idx;
        end
      end
      if (found) begin
        m_valid = 1'b1;
        m_ch    = g[CHW-1:0];
        m_rise  = m_pol[g];
        m_pend[g] = 1'b0;
        m_rr    = g;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < N_SW; i++) begin
      logic hit;
      hit = 1'b0;
`ifdef DEBNC_EARLY_EN
      if (m_left[i] == 0) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_lvl[i]  = m_s2[i];
          m_left[i] = N_TICKS;
          hit = 1'b1;
        end
      end else if (tk) begin
        m_left[i] = m_left[i] - 1;
      end
`else
      if (m_left[i] == 0) begin
        if (m_s2[i] != m_lvl[i]) m_left[i] = N_TICKS;
      end else if (m_s2[i] == m_lvl[i]) begin
        m_left[i] = 0;
      end else if (tk) begin
        m_left[i] = m_left[i] - 1;
        if (m_left[i] == 0) begin
          m_lvl[i] = ~m_lvl[i];
          hit = 1'b1;
        end
      end
`endif
      if (hit) begin
        if (m_pend[i]) m_ovf = 1'b1;
        m_pend[i] = 1'b1;
        m_pol[i]  = m_lvl[i];
      end
    end
    m_s2 = m_s1;
    m_s1 = sw;
    m_phase = (m_phase + 1) % TICK_DIV;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic [VW-1:0] got_vec();
    return {db_level, evt_valid, evt_ovf, evt_valid ? {evt_ch, evt_rise} : {(CHW+1){1'b0}}};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {m_lvl, m_valid, m_ovf, m_valid ? {m_ch, m_rise} : {(CHW+1){1'b0}}};
  endfunction

  // Assert reset between edges and release it mid-cycle.
  task automatic do_reset();
    rst = 1'b1;
    #3;
    model_reset();
    @(posedge clk);
    #5;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sw = 4'hF; evt_ready = 1'b0;
    #5;
    total++;
    if ({db_level, evt_valid, evt_ovf} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_during got db=%b v=%b ovf=%b want 0", db_level, evt_valid, evt_ovf);
    end
    #3;
    rst = 1'b0;
    model_reset();
    step();
    total++;
    if ({db_level, evt_valid, evt_ovf} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_after got db=%b v=%b ovf=%b want 0", db_level, evt_valid, evt_ovf);
    end
    sw = '0;
    evt_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL reset_model cyc=%0d got=%b want=%b", n, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_glitch();
    logic seen_db0, seen_valid;
    bit   evq[$];
    do_reset();
    evt_ready = 1'b1;
    sw = 4'b0001;
    seen_db0 = 1'b0; seen_valid = 1'b0;
    for (int n = 0; n < 32; n++) begin
      step();
      if (n == 1) sw = 4'b0000;
      seen_db0   = seen_db0 | db_level[0];
      seen_valid = seen_valid | evt_valid;
      if (evt_valid && evt_ch == 0) evq.push_back(evt_rise);
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL glitch_model cyc=%0d got=%b want=%b", n, got_vec(), exp_vec());
      end
    end
`ifdef DEBNC_EARLY_EN
    total++;
    if (evq.size() != 2 || evq[0] != 1'b1 || evq[1] != 1'b0) begin
      bad++;
      $display("[TB] FAIL glitch_early_events got n=%0d want rise then fall", evq.size());
    end
`else
    total++;
    if (seen_db0 !== 1'b0 || seen_valid !== 1'b0 || evq.size() != 0) begin
      bad++;
      $display("[TB] FAIL glitch_suppressed got db0=%b valid=%b want 0 0", seen_db0, seen_valid);
    end
`endif
  endtask

  task automatic test_press();
    int first_db, n_valid, n_match;
    do_reset();
    evt_ready = 1'b1;
    sw = 4'b0010;
    first_db = -1; n_valid = 0; n_match = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (db_level[1] && first_db < 0) first_db = n;
      if (evt_valid) n_valid++;
      if (evt_valid && evt_ch == 1 && evt_rise) n_match++;
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL press_model cyc=%0d got=%b want=%b", n, got_vec(), exp_vec());
      end
    end
`ifdef DEBNC_EARLY_EN
    total++;
    if (first_db != 3) begin
      bad++;
      $display("[TB] FAIL press_latency got=%0d want=3", first_db);
    end
`else
    total++;
    if (first_db < 11 || first_db > 15) begin
      bad++;
      $display("[TB] FAIL press_latency got=%0d want 11..15", first_db);
    end
`endif
    total++;
    if (n_valid != 1 || n_match != 1) begin
      bad++;
      $display("[TB] FAIL press_event got valid_cycles=%0d ch1_rise=%0d want 1 1", n_valid, n_match);
    end
    sw = '0;
    for (int n = 0; n < 30; n++) begin
      step();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL press_release_model cyc=%0d got=%b want=%b", n, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_arbitration();
    bit seen;
    do_reset();
    evt_ready = 1'b0;
    sw = 4'b0101;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      step();
      seen = evt_valid;
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL arb_model cyc=%0d got=%b want=%b", n, got_vec(), exp_vec());
      end
    end
    total++;
    if (!seen) begin
      bad++;
      $display("[TB] FAIL arb_timeout got valid=0 want 1 within 40 cycles");
    end
    for (int n = 0; n < 20; n++) begin
      step();
      total++;
      if (!(evt_valid === 1'b1 && evt_ch === 2'd0 && evt_rise === 1'b1)) begin
        bad++;
        $display("[TB] FAIL arb_hold cyc=%0d got v=%b ch=%0d r=%b want 1 0 1", n, evt_valid, evt_ch, evt_rise);
      end
    end
    evt_ready = 1'b1;
    step();
    total++;
    if (!(evt_valid === 1'b1 && evt_ch === 2'd2 && evt_rise === 1'b1)) begin
      bad++;
      $display("[TB] FAIL arb_second got v=%b ch=%0d r=%b want 1 2 1", evt_valid, evt_ch, evt_rise);
    end
    step();
    total++;
    if (evt_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL arb_drained got v=%b want 0", evt_valid);
    end
    sw = '0;
    for (int n = 0; n < 30; n++) begin
      step();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL arb_release_model cyc=%0d got=%b want=%b", n, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    evt_ready = 1'b0;
    sw = 4'b0001;
    for (int n = 0; n < 60; n++) begin
      if (n == 20) sw = 4'b1001;
      if (n == 40) sw = 4'b0001;
      step();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL ovf_model cyc=%0d got=%b want=%b", n, got_vec(), exp_vec());
      end
    end
    total++;
    if (!(evt_ovf === 1'b1 && evt_valid === 1'b1 && evt_ch === 2'd0 && evt_rise === 1'b1)) begin
      bad++;
      $display("[TB] FAIL ovf_flag got ovf=%b v=%b ch=%0d r=%b want 1 1 0 1", evt_ovf, evt_valid, evt_ch, evt_rise);
    end
    evt_ready = 1'b1;
    step();
    total++;
    if (!(evt_valid === 1'b1 && evt_ch === 2'd3 && evt_rise === 1'b0)) begin
      bad++;
      $display("[TB] FAIL ovf_ch3_fall got v=%b ch=%0d r=%b want 1 3 0", evt_valid, evt_ch, evt_rise);
    end
    step();
    total++;
    if (evt_valid !== 1'b0 || evt_ovf !== 1'b1) begin
      bad++;
      $display("[TB] FAIL ovf_drained got v=%b ovf=%b want 0 1", evt_valid, evt_ovf);
    end
    sw = '0;
    for (int n = 0; n < 30; n++) begin
      step();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL ovf_release_model cyc=%0d got=%b want=%b", n, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_mid_reset();
    int first_db, n_match;
    do_reset();
    evt_ready = 1'b1;
    sw = 4'b0100;
    for (int n = 0; n < 6; n++) begin
      step();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL midrst_pre_model cyc=%0d got=%b want=%b", n, got_vec(), exp_vec());
      end
    end
    #4;
    rst = 1'b1;
    #1;
    total++;
    if (db_level !== '0 || evt_valid !== 1'b0) begin
      bad++;
      $display("[TB] FAIL midrst_abort got db=%b v=%b want 0 0", db_level, evt_valid);
    end
    model_reset();
    @(posedge clk);
    #5;
    rst = 1'b0;
    first_db = -1; n_match = 0;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (db_level[2] && first_db < 0) first_db = n;
      if (evt_valid && evt_ch == 2 && evt_rise) n_match++;
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL midrst_model cyc=%0d got=%b want=%b", n, got_vec(), exp_vec());
      end
    end
`ifdef DEBNC_EARLY_EN
    total++;
    if (first_db != 3 || n_match != 1) begin
      bad++;
      $display("[TB] FAIL midrst_relatch got lat=%0d ev=%0d want 3 1", first_db, n_match);
    end
`else
    total++;
    if (first_db < 11 || first_db > 15 || n_match != 1) begin
      bad++;
      $display("[TB] FAIL midrst_relatch got lat=%0d ev=%0d want 11..15 1", first_db, n_match);
    end
`endif
  endtask

  task automatic test_random();
    int hold [N_SW];
    do_reset();
    sw = '0;
    evt_ready = 1'b1;
    for (int i = 0; i < N_SW; i++) hold[i] = $urandom_range(1, 24);
    for (int n = 0; n < 1500; n++) begin
      step();
      total++;
      if (got_vec() !== exp_vec()) begin
        bad++;
        $display("[TB] FAIL random_model cyc=%0d got=%b want=%b", n, got_vec(), exp_vec());
      end
      for (int i = 0; i < N_SW; i++) begin
        hold[i]--;
        if (hold[i] <= 0) begin
          sw[i]   = ~sw[i];
          hold[i] = $urandom_range(1, 24);
        end
      end
      evt_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_glitch();
    test_press();
    test_arbitration();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
